// File: rtl/top_level_display_if.sv
// Board-side signal bundle for top_level_display: switches, button, LEDs and six digits.
// The slave modport is the design's view; the master modport is the board/stimulus view.
interface top_level_display_if;
  logic [9:0] SW;
  logic       button;
  logic [9:0] LEDR;
  logic [7:0] HEX0;
  logic [7:0] HEX1;
  logic [7:0] HEX2;
  logic [7:0] HEX3;
  logic [7:0] HEX4;
  logic [7:0] HEX5;

  modport master (
    output SW, button,
    input  LEDR, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
  );

  modport slave (
    input  SW, button,
    output LEDR, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
  );
endinterface

// File: rtl/top_level_display.sv
// Lab top: debounced-load hold register, moving average, voltage/distance scaling
// and a four-mode six-digit seven-segment display.
module top_level_display #(
  parameter int unsigned DEBOUNCE_CYCLES = 5000000,
  parameter int unsigned AVG_DEPTH_LOG2  = 4
) (
  input logic                clk,
  input logic                reset_n,
  top_level_display_if.slave board
);

  localparam int unsigned AvgDepth = 1 << AVG_DEPTH_LOG2;
  localparam int unsigned CntW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned SumW     = 8 + AVG_DEPTH_LOG2;

  logic            sync1_q, sync2_q;
  logic            we_q, we_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      reg_q, reg_d;
  logic [7:0]      win_q [AvgDepth];
  logic [7:0]      win_d [AvgDepth];
  logic [SumW-1:0] sum_q, sum_d;

  logic [12:0] avg_out;
  logic [12:0] voltage;
  logic [12:0] distance;
  logic [15:0] digits;
  logic [3:0]  dp;

  function automatic logic [15:0] bin2bcd(input logic [12:0] bin);
    logic [15:0] bcd;
    bcd = '0;
    for (int i = 12; i >= 0; i--) begin
      for (int d = 0; d < 4; d++) begin
        if (bcd[d*4 +: 4] >= 4'd5) bcd[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
      end
      bcd = {bcd[14:0], bin[i]};
    end
    return bcd;
  endfunction

  // Active-low segments, bit order gfedcba.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0011000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      reg_q   <= '0;
      win_q   <= '{default: '0};
      sum_q   <= '0;
    end else begin
      sync1_q <= board.button;
      sync2_q <= sync1_q;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      reg_q   <= reg_d;
      win_q   <= win_d;
      sum_q   <= sum_d;
    end
  end

  // Count only while the synchronised level differs from the debounced one;
  // any return to the debounced level restarts the count.
  always_comb begin
    cnt_d = '0;
    we_d  = we_q;
    if (sync2_q != we_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        we_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // Running sum tracks the window contents exactly, both starting from zero.
  always_comb begin
    reg_d    = we_q ? board.SW[7:0] : reg_q;
    win_d[0] = reg_q;
    for (int unsigned i = 1; i < AvgDepth; i++) win_d[i] = win_q[i-1];
    sum_d    = sum_q + SumW'(reg_q) - SumW'(win_q[AvgDepth-1]);
  end

  always_comb begin
    avg_out  = 13'(sum_q >> AVG_DEPTH_LOG2);
    voltage  = 13'((21'(reg_q) * 21'd5000) >> 8);
    distance = 13'd5000 - voltage;
  end

  always_comb begin
    digits = '0;
    dp     = '0;
    unique case (board.SW[9:8])
      2'b00: digits = {8'h00, reg_q};
      2'b01: digits = {3'b000, avg_out};
      2'b10: begin
        digits = bin2bcd(distance);
        dp     = 4'b0100;
      end
      default: begin
        digits = bin2bcd(voltage);
        dp     = 4'b1000;
      end
    endcase
  end

  assign board.LEDR = board.SW;
  assign board.HEX0 = {~dp[0], seg7(digits[3:0])};
  assign board.HEX1 = {~dp[1], seg7(digits[7:4])};
  assign board.HEX2 = {~dp[2], seg7(digits[11:8])};
  assign board.HEX3 = {~dp[3], seg7(digits[15:12])};
  assign board.HEX4 = 8'hFF;
  assign board.HEX5 = 8'hFF;

endmodule

// File: tb/tb_top_level_display.sv
// Randomised self-checking bench for top_level_display against an arithmetic model
// of the hold register, 16-sample average and the four display modes.
module tb_top_level_display;

  localparam int unsigned Deb = 200;

  logic clk = 1'b0;
  logic reset_n;

  top_level_display_if bus ();

  top_level_display #(
    .DEBOUNCE_CYCLES(Deb),
    .AVG_DEPTH_LOG2 (4)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .board  (bus)
  );

  always #5 clk = ~clk;

  int         checks   = 0;
  int         failures = 0;
  logic [6:0] seg_tab [16];
  logic [7:0] reg_m;
  bit         we_m;
  bit         tracking;
  int         hist [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_avg();
    int s;
    s = 0;
    foreach (hist[i]) s += hist[i];
    return s / 16;
  endfunction

  function automatic logic [47:0] model_disp(input logic [1:0] mode, input int r, input int a);
    int         val;
    int         v;
    int         div;
    logic [3:0] dig;
    logic [3:0] dpm;
    logic [47:0] res;
    v   = (r * 5000) / 256;
    dpm = 4'b0000;
    case (mode)
      2'd0: val = r;
      2'd1: val = a;
      2'd2: begin val = 5000 - v; dpm = 4'b0100; end
      default: begin val = v; dpm = 4'b1000; end
    endcase
    res = '1;
    div = 1;
    for (int k = 0; k < 4; k++) begin
      if (mode < 2) dig = 4'((val >> (4 * k)) & 15);
      else          dig = 4'((val / div) % 10);
      div = div * 10;
      res[8*k +: 8] = {~dpm[k], seg_tab[dig]};
    end
    return res;
  endfunction

  function automatic logic [47:0] disp_now();
    return {bus.HEX5, bus.HEX4, bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0};
  endfunction

  task automatic tick();
    logic [7:0] sw_now;
    sw_now = bus.SW[7:0];
    @(posedge clk);
    if (tracking) begin
      hist.push_front(int'(reg_m));
      void'(hist.pop_back());
      if (we_m) reg_m = sw_now;
    end
    #1;
  endtask

  task automatic check_disp(input string tag);
    check_eq(tag, 64'(disp_now()), 64'(model_disp(bus.SW[9:8], int'(reg_m), model_avg())));
  endtask

  task automatic fill_hist(input int v);
    hist = {};
    for (int i = 0; i < 16; i++) hist.push_back(v);
  endtask

  task automatic do_reset();
    bus.button = 1'b0;
    reset_n    = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    reset_n  = 1'b1;
    reg_m    = 8'h00;
    we_m     = 1'b0;
    tracking = 1'b1;
    fill_hist(0);
  endtask

  initial begin
    seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
    seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
    seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
    seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
    seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0011000;
    seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
    seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001;
    seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;
    bus.SW     = '0;
    bus.button = 1'b0;
    reset_n    = 1'b0;

    // Reset in every mode
    for (int m = 0; m < 4; m++) begin
      bus.SW = {2'(m), 8'h00};
      do_reset();
      check_disp($sformatf("reset_mode%0d", m));
      check_eq("reset_blank", 64'({bus.HEX5, bus.HEX4}), 64'hFFFF);
      if (m == 0) check_eq("reset_hex_zero", 64'(disp_now()), 64'hFFFF_C0C0_C0C0);
    end
    tick();
    check_eq("ledr_mirror", 64'(bus.LEDR), 64'h300);

    // Enable through the debouncer; load must not happen early
    bus.SW     = 10'h0A7;
    bus.button = 1'b1;
    tracking   = 1'b0;
    repeat (Deb - 1) tick();
    check_eq("we_early", 64'({bus.HEX1, bus.HEX0}), 64'hC0C0);
    repeat (7) tick();
    check_eq("we_late", 64'({bus.HEX1, bus.HEX0}), 64'({8'b10001000, 8'b11111000}));
    repeat (16) tick();
    reg_m    = 8'hA7;
    we_m     = 1'b1;
    tracking = 1'b1;
    fill_hist(int'(8'hA7));

    // Hex sweep
    for (int i = 0; i < 256; i++) begin
      bus.SW = {2'b00, 8'(i)};
      tick();
      check_disp($sformatf("sweep_%02h", i));
    end
    check_eq("ledr_sweep", 64'(bus.LEDR), 64'h0FF);

    // Distance for 0x80: 25.00 with the point on HEX2
    bus.SW = {2'b10, 8'h80};
    tick();
    check_eq("dist_80", 64'(disp_now()), 64'hFFFF_A412_C0C0);
    check_disp("dist_80_model");

    // Voltage for 0xFF: 4.980 with the point on HEX3
    bus.SW = {2'b11, 8'hFF};
    tick();
    check_eq("volt_ff", 64'(disp_now()), 64'hFFFF_1998_80C0);

    // Average settles on a held value
    bus.SW = {2'b01, 8'h40};
    repeat (20) tick();
    check_eq("avg_40", 64'(disp_now()), 64'hFFFF_C0C0_99C0);
    check_disp("avg_40_model");

    // Random mode/data while enabled
    for (int i = 0; i < 400; i++) begin
      bus.SW = 10'($urandom);
      tick();
      check_disp($sformatf("rand_%0d", i));
    end

    // Freeze at 0xFF
    bus.SW     = {2'b00, 8'hFF};
    bus.button = 1'b0;
    repeat (Deb + 10) tick();
    we_m   = 1'b0;
    bus.SW = {2'b00, 8'h00};
    tick();
    check_eq("freeze_ff", 64'({bus.HEX1, bus.HEX0}), 64'h8E8E);
    check_disp("freeze_model");

    // Short glitch must not re-enable loading
    bus.button = 1'b1;
    repeat (100) tick();
    bus.button = 1'b0;
    repeat (Deb + 10) tick();
    check_eq("glitch_hold", 64'({bus.HEX1, bus.HEX0}), 64'h8E8E);

    for (int i = 0; i < 60; i++) begin
      bus.SW = 10'($urandom);
      tick();
      check_disp($sformatf("frozen_rand_%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
